// File: rtl/busreq_ctrl_pkg.sv
// Shared types and defaults for the burst-request controller.
// Holds the per-channel state encoding and the default channel/length sizing.
package busreq_ctrl_pkg;

    localparam int NCH_DEF  = 3;
    localparam int LENW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } chan_state_e;

    // A channel holds its request line while it is waiting for or moving data.
    function automatic logic is_active(input chan_state_e st);
        return (st == REQ) || (st == XFER);
    endfunction

endpackage

// File: rtl/busreq_chan.sv
// One requester channel: burst FSM plus remaining-beat counter.
// Beat and err follow gnt within the cycle; all other outputs decode registered state.
module busreq_chan
    import busreq_ctrl_pkg::*;
#(
    parameter int LENW = LENW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LENW-1:0] len,
    input  logic            gnt,
    input  logic            multihot,
    output logic            req,
    output logic            beat,
    output logic            busy,
    output logic            done,
    output logic            err
);

    chan_state_e     state_r, state_s;
    logic [LENW-1:0] cnt_r, cnt_s;
    logic            beat_s, err_s;

    // Next-state, counter and grant-qualified outputs.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        beat_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                err_s = gnt;
                if (start) begin
                    cnt_s   = len;
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ, XFER: begin
                // A multi-hot grant is a bus fault: nobody gets to count a beat.
                if (gnt && !multihot) begin
                    beat_s = 1'b1;
                    if (cnt_r == {LENW{1'b0}}) begin
                        state_s = DONE;
                    end else begin
                        cnt_s   = cnt_r - {{(LENW-1){1'b0}}, 1'b1};
                        state_s = XFER;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            DONE: begin
                err_s   = gnt;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {LENW{1'b0}};
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {LENW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    assign req  = is_active(state_r);
    assign busy = is_active(state_r);
    assign done = (state_r == DONE);
    assign beat = beat_s;
    assign err  = err_s;

endmodule

// File: rtl/busreq_ctrl.sv
// Burst-request controller: NCH independent channels sharing a fixed-priority bus.
// Adds the multi-hot grant check that suppresses beats and flags every granted channel.
module busreq_ctrl
    import busreq_ctrl_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int LENW = LENW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      start,
    input  logic [NCH*LENW-1:0] len,
    input  logic [NCH-1:0]      gnt,
    output logic [NCH-1:0]      req,
    output logic [NCH-1:0]      beat,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      done,
    output logic [NCH-1:0]      err
);

    logic           multihot_s;
    logic [NCH-1:0] chan_err_s;

    // More than one bit set iff clearing the lowest set bit leaves something.
    assign multihot_s = |(gnt & (gnt - {{(NCH-1){1'b0}}, 1'b1}));

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        busreq_chan #(
            .LENW(LENW)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .start   (start[i]),
            .len     (len[i*LENW +: LENW]),
            .gnt     (gnt[i]),
            .multihot(multihot_s),
            .req     (req[i]),
            .beat    (beat[i]),
            .busy    (busy[i]),
            .done    (done[i]),
            .err     (chan_err_s[i])
        );
    end

    assign err = chan_err_s | (gnt & {NCH{multihot_s}});

endmodule

// File: tb/tb_busreq_ctrl.sv
// Scoreboard bench for busreq_ctrl: directed bursts push expected per-cycle events,
// a monitor pops and compares whenever beat, done or err is non-zero.
module tb_busreq_ctrl;

    localparam int NCH  = 3;
    localparam int LENW = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      start;
    logic [NCH*LENW-1:0] len;
    logic [NCH-1:0]      gnt, req, beat, busy, done, err;

    logic                force_en;
    logic [NCH-1:0]      gnt_force, mask, arb_m;
    logic                mon_en = 1'b0;
    int                  cyc = 0;
    int                  checks = 0;
    int                  errors = 0;

    typedef struct packed {
        int             c;
        logic [NCH-1:0] rq;
        logic [NCH-1:0] bt;
        logic [NCH-1:0] dn;
        logic [NCH-1:0] er;
    } ev_t;

    ev_t expq[$];

    busreq_ctrl #(.NCH(NCH), .LENW(LENW)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .len  (len),
        .gnt  (gnt),
        .req  (req),
        .beat (beat),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-priority arbiter model (channel 0 highest), with a per-channel mask and a force override.
    always_comb begin
        arb_m = req & ~mask;
        gnt   = force_en ? gnt_force : (arb_m & (~arb_m + 3'd1));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ex(input int c, input logic [2:0] rq, input logic [2:0] bt,
                      input logic [2:0] dn, input logic [2:0] er);
        ev_t e;
        e.c  = c;
        e.rq = rq;
        e.bt = bt;
        e.dn = dn;
        e.er = er;
        expq.push_back(e);
    endtask

    initial begin
        int c0;
        int c1;
        int c2;
        rst       = 1'b1;
        start     = 3'b000;
        len       = 12'h000;
        force_en  = 1'b0;
        gnt_force = 3'b000;
        mask      = 3'b000;

        fork
            forever begin
                @(negedge clk);
                if (mon_en && ((beat | done | err) != 3'b000)) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event cyc=%0d req=%b beat=%b done=%b err=%b expected none",
                                 cyc, req, beat, done, err);
                    end else begin
                        ev_t e;
                        e = expq.pop_front();
                        if (e.c != cyc || e.rq != req || e.bt != beat || e.dn != done || e.er != err) begin
                            errors++;
                            $display("FAIL event got cyc=%0d req=%b beat=%b done=%b err=%b expected cyc=%0d req=%b beat=%b done=%b err=%b",
                                     cyc, req, beat, done, err, e.c, e.rq, e.bt, e.dn, e.er);
                        end
                    end
                end
            end
        join_none

        // Reset state
        step(3);
        checks += 5;
        if (req  != 3'b000) begin errors++; $display("FAIL rst_req got %b expected 000", req);   end
        if (beat != 3'b000) begin errors++; $display("FAIL rst_beat got %b expected 000", beat); end
        if (busy != 3'b000) begin errors++; $display("FAIL rst_busy got %b expected 000", busy); end
        if (done != 3'b000) begin errors++; $display("FAIL rst_done got %b expected 000", done); end
        if (err  != 3'b000) begin errors++; $display("FAIL rst_err got %b expected 000", err);   end
        rst    = 1'b0;
        mon_en = 1'b1;
        step(2);

        // Single burst ch0, len=2 -> 3 beats then done with req low
        start = 3'b001; len = 12'h002; c0 = cyc;
        ex(c0+1, 3'b001, 3'b001, 3'b000, 3'b000);
        ex(c0+2, 3'b001, 3'b001, 3'b000, 3'b000);
        ex(c0+3, 3'b001, 3'b001, 3'b000, 3'b000);
        ex(c0+4, 3'b000, 3'b000, 3'b001, 3'b000);
        step(1); start = 3'b000;
        step(5);

        // All three channels, len=0, priority order
        start = 3'b111; len = 12'h000; c0 = cyc;
        ex(c0+1, 3'b111, 3'b001, 3'b000, 3'b000);
        ex(c0+2, 3'b110, 3'b010, 3'b001, 3'b000);
        ex(c0+3, 3'b100, 3'b100, 3'b010, 3'b000);
        ex(c0+4, 3'b000, 3'b000, 3'b100, 3'b000);
        step(1); start = 3'b000;
        step(5);

        // ch1 len=3 with grant dropped for two cycles after beat 2
        start = 3'b010; len = 12'h030; c0 = cyc;
        ex(c0+1, 3'b010, 3'b010, 3'b000, 3'b000);
        ex(c0+2, 3'b010, 3'b010, 3'b000, 3'b000);
        ex(c0+5, 3'b010, 3'b010, 3'b000, 3'b000);
        ex(c0+6, 3'b010, 3'b010, 3'b000, 3'b000);
        ex(c0+7, 3'b000, 3'b000, 3'b010, 3'b000);
        step(1); start = 3'b000;
        step(2); mask = 3'b010;
        checks++;
        if (busy != 3'b010) begin errors++; $display("FAIL hold_busy got %b expected 010", busy); end
        step(2); mask = 3'b000;
        step(4);

        // Grant to an idle channel, then a multi-hot grant while two channels request
        force_en = 1'b1; gnt_force = 3'b010; c0 = cyc;
        ex(c0, 3'b000, 3'b000, 3'b000, 3'b010);
        step(1); gnt_force = 3'b000; len = 12'h000; start = 3'b011;
        step(1); start = 3'b000; gnt_force = 3'b011; c1 = cyc;
        ex(c1, 3'b011, 3'b000, 3'b000, 3'b011);
        step(1); gnt_force = 3'b000;
        step(1); force_en = 1'b0; c2 = cyc;
        ex(c2,   3'b011, 3'b001, 3'b000, 3'b000);
        ex(c2+1, 3'b010, 3'b010, 3'b001, 3'b000);
        ex(c2+2, 3'b000, 3'b000, 3'b010, 3'b000);
        step(4);

        // Reset mid-burst abandons it; a fresh len=1 burst gives exactly 2 beats
        start = 3'b001; len = 12'h003; c0 = cyc;
        ex(c0+1, 3'b001, 3'b001, 3'b000, 3'b000);
        ex(c0+2, 3'b001, 3'b001, 3'b000, 3'b000);
        step(1); start = 3'b000;
        step(2); mask = 3'b001; rst = 1'b1;
        step(1); rst = 1'b0; mask = 3'b000;
        checks += 5;
        if (req  != 3'b000) begin errors++; $display("FAIL midrst_req got %b expected 000", req);   end
        if (beat != 3'b000) begin errors++; $display("FAIL midrst_beat got %b expected 000", beat); end
        if (busy != 3'b000) begin errors++; $display("FAIL midrst_busy got %b expected 000", busy); end
        if (done != 3'b000) begin errors++; $display("FAIL midrst_done got %b expected 000", done); end
        if (err  != 3'b000) begin errors++; $display("FAIL midrst_err got %b expected 000", err);   end
        start = 3'b001; len = 12'h001; c1 = cyc;
        ex(c1+1, 3'b001, 3'b001, 3'b000, 3'b000);
        ex(c1+2, 3'b001, 3'b001, 3'b000, 3'b000);
        ex(c1+3, 3'b000, 3'b000, 3'b001, 3'b000);
        step(1); start = 3'b000;
        step(4);

        // start held high through the burst and DONE, with len changing, is ignored
        start = 3'b001; len = 12'h002; c0 = cyc;
        ex(c0+1, 3'b001, 3'b001, 3'b000, 3'b000);
        ex(c0+2, 3'b001, 3'b001, 3'b000, 3'b000);
        ex(c0+3, 3'b001, 3'b001, 3'b000, 3'b000);
        ex(c0+4, 3'b000, 3'b000, 3'b001, 3'b000);
        step(1); len = 12'h003;
        step(1);
        checks++;
        if (busy != 3'b001) begin errors++; $display("FAIL busy_during got %b expected 001", busy); end
        step(3); start = 3'b000;
        step(3);

        // len all-ones -> 16 beats
        start = 3'b001; len = 12'h00F; c0 = cyc;
        for (int k = 1; k <= 16; k++) ex(c0+k, 3'b001, 3'b001, 3'b000, 3'b000);
        ex(c0+17, 3'b000, 3'b000, 3'b001, 3'b000);
        step(1); start = 3'b000;
        step(19);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d pending expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/busreq_ctrl.md
BUSREQ_CTRL -- requirements
Module: busreq_ctrl

Interface
REQ-001 Parameter NCH, default 3, SHALL set the number of requester channels; bit i of every vector port belongs to channel i.
REQ-002 Parameter LENW, default 4, SHALL set the burst-length field width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-005 Port start, input, NCH, SHALL be a per-channel one-cycle request to begin a burst.
REQ-006 Port len, input, NCH*LENW, SHALL give the per-channel burst length minus one; slice i is len[i*LENW +: LENW].
REQ-007 Port gnt, input, NCH, SHALL be the one-hot grant vector from the fixed-priority bus arbiter.
REQ-008 Port req, output, NCH, SHALL be the request vector driven to the arbiter.
REQ-009 Port beat, output, NCH, SHALL flag a counted transfer beat for the channel this cycle.
REQ-010 Port busy, output, NCH, SHALL be high while the channel is in REQ or XFER.
REQ-011 Port done, output, NCH, SHALL pulse for one cycle when the channel's burst completes.
REQ-012 Port err, output, NCH, SHALL pulse for one cycle on a protocol violation for that channel.

Function
REQ-013 Each channel SHALL run an independent FSM with states IDLE, REQ, XFER, DONE.
REQ-014 IDLE: start[i]=1 SHALL latch len slice into the channel's remaining-beat counter and move to REQ; req[i] is high from the next cycle.
REQ-015 REQ: req[i]=1; gnt[i]=1 while gnt is one-hot SHALL count beat 1 (beat[i]=1) and move to XFER, or to DONE if the counter is 0.
REQ-016 XFER: req[i]=1; each cycle with gnt[i]=1 and one-hot gnt SHALL assert beat[i] and decrement the counter; the beat taken with counter 0 moves to DONE.
REQ-017 Grant loss mid-burst (gnt[i]=0 in XFER) SHALL hold state and counter, beat[i]=0, req[i] stays 1.
REQ-018 DONE: req[i]=0, done[i]=1 for exactly one cycle, then IDLE; a burst of len=N yields exactly N+1 beats.
REQ-019 start[i] while not IDLE (including DONE) SHALL be ignored with no effect on the counter.
REQ-020 gnt[i]=1 while channel i is IDLE or DONE SHALL pulse err[i]; no state change.
REQ-021 Multi-hot gnt SHALL pulse err on every asserted bit and count no beat on any channel that cycle.
REQ-022 busy[i] SHALL equal (state is REQ or XFER); all outputs registered or decoded from registered state only; gnt-to-beat is combinational within the cycle.
REQ-023 Counter SHALL be LENW bits, never wrap below 0; len=all-ones yields 2^LENW beats.

Reset
REQ-024 rst=1 at a clock edge SHALL force every channel to IDLE, counter to 0, and req, beat, busy, done, err to 0, overriding start and gnt that cycle.
REQ-025 rst asserted mid-burst SHALL abandon the burst with no done pulse.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, REQ, XFER, DONE) and default NCH/LENW constants.
REQ-027 One sub-module busreq_chan SHALL implement a single channel FSM and counter; busreq_ctrl instantiates NCH copies plus the multi-hot grant check.

Verification
REQ-028 start[0]=1, len0=2, gnt tracks req with channel 0 priority -> req[0] high at t+1, beat[0] on 3 consecutive cycles, done[0] one cycle, req[0] low in DONE.
REQ-029 start[2:0]=111, all len=0, fixed-priority grants -> beats in order ch0, ch1, ch2, one each; three done pulses in that order.
REQ-030 ch1 len=3, gnt[1] dropped for 2 cycles after beat 2 -> beat[1] low for 2 cycles, counter holds, total 4 beats, then done[1].
REQ-031 gnt=010 with channel 1 IDLE -> err[1]=1 one cycle; gnt=011 while both request -> err[0]=err[1]=1, no beats.
REQ-032 rst during XFER of ch0 (2 beats left) -> next cycle all outputs 0, no done; later start[0] with len=1 -> exactly 2 beats.
REQ-033 start[0] repeated while busy[0]=1 -> ignored; exactly len0+1 beats and one done.
